// File: rtl/axi_tdd_ng_seq_counter.sv
// axi_tdd_ng_seq_counter: frame timebase for the axi_tdd_ng channel comparators.
// Runs a startup delay, then a burst of frames of tdd_frame_length ticks each.
// A tick is one clk out of every tdd_prescale+1.
// Start sources: software pulse, edge-detected external sync, internal periodic generator.
//
// Ports:
//   i_clk, i_rst            core clock, synchronous active-high reset
//   i_tdd_enable            level; low forces IDLE and clears all state
//   i_tdd_sync_ext(_en)     external sync level (rising edge used) and its enable
//   i_tdd_sync_int_en       enables the internal periodic sync generator
//   i_tdd_sync_soft         one-cycle software sync
//   i_tdd_sync_rst          a sync in WAITING/RUNNING restarts the sequence
//   i_tdd_stop              one-cycle request: finish current frame, back to ARMED
//   i_tdd_prescale          tick every i_tdd_prescale+1 clk
//   i_tdd_burst_count       frames per burst, 0 = infinite
//   i_tdd_startup_delay     ticks from sync to first frame
//   i_tdd_frame_length      ticks per frame, 0 behaves as 1
//   i_tdd_sync_period       internal sync period in clk, 0 = no pulses
//   o_tdd_counter           tick count within delay/frame
//   o_tdd_cstate            IDLE=0, ARMED=1, WAITING=2, RUNNING=3
//   o_tdd_tick              prescaler tick while WAITING/RUNNING
//   o_tdd_endof_frame       pulse during the terminal tick of each frame
//   o_tdd_frame_index       0-based frame number within the burst
//   o_tdd_burst_done        pulse with the last endof_frame of a finite burst
module axi_tdd_ng_seq_counter #(
  parameter int unsigned REGISTER_WIDTH    = 32,
  parameter int unsigned BURST_COUNT_WIDTH = 32,
  parameter int unsigned PRESCALER_WIDTH   = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_tdd_enable,
  input  logic                         i_tdd_sync_ext,
  input  logic                         i_tdd_sync_ext_en,
  input  logic                         i_tdd_sync_int_en,
  input  logic                         i_tdd_sync_soft,
  input  logic                         i_tdd_sync_rst,
  input  logic                         i_tdd_stop,
  input  logic [PRESCALER_WIDTH-1:0]   i_tdd_prescale,
  input  logic [BURST_COUNT_WIDTH-1:0] i_tdd_burst_count,
  input  logic [REGISTER_WIDTH-1:0]    i_tdd_startup_delay,
  input  logic [REGISTER_WIDTH-1:0]    i_tdd_frame_length,
  input  logic [REGISTER_WIDTH-1:0]    i_tdd_sync_period,
  output logic [REGISTER_WIDTH-1:0]    o_tdd_counter,
  output logic [1:0]                   o_tdd_cstate,
  output logic                         o_tdd_tick,
  output logic                         o_tdd_endof_frame,
  output logic [BURST_COUNT_WIDTH-1:0] o_tdd_frame_index,
  output logic                         o_tdd_burst_done
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StWaiting = 2'd2,
    StRunning = 2'd3
  } state_e;

  localparam logic [REGISTER_WIDTH-1:0]    RegOne   = REGISTER_WIDTH'(1);
  localparam logic [BURST_COUNT_WIDTH-1:0] BurstOne = BURST_COUNT_WIDTH'(1);
  localparam logic [PRESCALER_WIDTH-1:0]   PreOne   = PRESCALER_WIDTH'(1);

  state_e                       r_state;
  logic [REGISTER_WIDTH-1:0]    r_counter;
  logic [PRESCALER_WIDTH-1:0]   r_prescaler;
  logic [BURST_COUNT_WIDTH-1:0] r_frame_index;
  logic                         r_stop;
  logic                         r_sync_ext_q;
  logic [REGISTER_WIDTH-1:0]    r_sync_gen;

  logic                         w_active;
  logic                         w_tick;
  logic                         w_gen_pulse;
  logic                         w_sync_event;
  logic                         w_resync;
  logic                         w_stop;
  logic                         w_term;
  logic                         w_last;
  logic [REGISTER_WIDTH-1:0]    w_len_m1;
  logic [REGISTER_WIDTH-1:0]    w_dly_m1;
  state_e                       w_start_state;

  assign w_active     = (r_state == StWaiting) || (r_state == StRunning);
  assign w_tick       = w_active && (r_prescaler == i_tdd_prescale);
  assign w_gen_pulse  = (i_tdd_sync_period != '0) && (r_sync_gen == i_tdd_sync_period - RegOne);
  assign w_sync_event = (i_tdd_sync_ext_en & i_tdd_sync_ext & ~r_sync_ext_q)
                      | (i_tdd_sync_int_en & w_gen_pulse)
                      | i_tdd_sync_soft;
  assign w_resync     = w_active && w_sync_event && i_tdd_sync_rst;
  // A stop arriving in the terminal clk itself still ends the sequence at that frame.
  assign w_stop       = r_stop | i_tdd_stop;
  // Zero length/delay compare as one, so a zero setting never waits for the counter to wrap.
  assign w_len_m1     = (i_tdd_frame_length == '0) ? '0 : i_tdd_frame_length - RegOne;
  assign w_dly_m1     = (i_tdd_startup_delay == '0) ? '0 : i_tdd_startup_delay - RegOne;
  assign w_term       = (r_state == StRunning) && w_tick && (r_counter == w_len_m1);
  assign w_last       = (i_tdd_burst_count != '0) &&
                        (r_frame_index == i_tdd_burst_count - BurstOne);
  assign w_start_state = (i_tdd_startup_delay != '0) ? StWaiting : StRunning;

  // Frame pulses are decoded from the registered counter so they line up with the clk
  // in which o_tdd_counter shows the terminal value; a resync in that clk cancels them.
  assign o_tdd_counter     = r_counter;
  assign o_tdd_cstate      = r_state;
  assign o_tdd_tick        = w_tick;
  assign o_tdd_frame_index = r_frame_index;
  assign o_tdd_endof_frame = w_term & ~w_resync;
  assign o_tdd_burst_done  = w_term & ~w_resync & ~w_stop & w_last;

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_tdd_enable) begin
      r_state       <= StIdle;
      r_counter     <= '0;
      r_prescaler   <= '0;
      r_frame_index <= '0;
      r_stop        <= 1'b0;
      r_sync_ext_q  <= 1'b0;
      r_sync_gen    <= '0;
    end else begin
      r_sync_ext_q <= i_tdd_sync_ext;
      r_sync_gen   <= (w_gen_pulse || (i_tdd_sync_period == '0)) ? '0 : r_sync_gen + RegOne;

      unique case (r_state)
        StIdle: r_state <= StArmed;

        StArmed: begin
          if (w_sync_event) begin
            r_state       <= w_start_state;
            r_counter     <= '0;
            r_prescaler   <= '0;
            r_frame_index <= '0;
          end
        end

        StWaiting: begin
          if (w_resync) begin
            r_state     <= w_start_state;
            r_counter   <= '0;
            r_prescaler <= '0;
            r_stop      <= 1'b0;
          end else if (i_tdd_stop) begin
            r_state     <= StArmed;
            r_counter   <= '0;
            r_prescaler <= '0;
          end else begin
            r_prescaler <= w_tick ? '0 : r_prescaler + PreOne;
            if (w_tick) begin
              if (r_counter == w_dly_m1) begin
                r_state   <= StRunning;
                r_counter <= '0;
              end else begin
                r_counter <= r_counter + RegOne;
              end
            end
          end
        end

        StRunning: begin
          if (w_resync) begin
            r_state       <= w_start_state;
            r_counter     <= '0;
            r_prescaler   <= '0;
            r_frame_index <= '0;
            r_stop        <= 1'b0;
          end else begin
            r_prescaler <= w_tick ? '0 : r_prescaler + PreOne;
            r_stop      <= w_stop;
            if (w_term) begin
              r_counter <= '0;
              if (w_stop || w_last) begin
                r_state       <= StArmed;
                r_frame_index <= '0;
                r_prescaler   <= '0;
                r_stop        <= 1'b0;
              end else begin
                r_frame_index <= r_frame_index + BurstOne;
              end
            end else if (w_tick) begin
              r_counter <= r_counter + RegOne;
            end
          end
        end

        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_tdd_ng_seq_counter.sv
module tb_axi_tdd_ng_seq_counter;

  logic        clk = 1'b0;
  logic        rst, tdd_enable, tdd_sync_ext, tdd_sync_ext_en, tdd_sync_int_en;
  logic        tdd_sync_soft, tdd_sync_rst, tdd_stop;
  logic [7:0]  tdd_prescale;
  logic [31:0] tdd_burst_count, tdd_startup_delay, tdd_frame_length, tdd_sync_period;
  logic [31:0] tdd_counter, tdd_frame_index;
  logic [1:0]  tdd_cstate;
  logic        tdd_tick, tdd_endof_frame, tdd_burst_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_tdd_ng_seq_counter #(
    .REGISTER_WIDTH(32),
    .BURST_COUNT_WIDTH(32),
    .PRESCALER_WIDTH(8)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_tdd_enable(tdd_enable),
    .i_tdd_sync_ext(tdd_sync_ext),
    .i_tdd_sync_ext_en(tdd_sync_ext_en),
    .i_tdd_sync_int_en(tdd_sync_int_en),
    .i_tdd_sync_soft(tdd_sync_soft),
    .i_tdd_sync_rst(tdd_sync_rst),
    .i_tdd_stop(tdd_stop),
    .i_tdd_prescale(tdd_prescale),
    .i_tdd_burst_count(tdd_burst_count),
    .i_tdd_startup_delay(tdd_startup_delay),
    .i_tdd_frame_length(tdd_frame_length),
    .i_tdd_sync_period(tdd_sync_period),
    .o_tdd_counter(tdd_counter),
    .o_tdd_cstate(tdd_cstate),
    .o_tdd_tick(tdd_tick),
    .o_tdd_endof_frame(tdd_endof_frame),
    .o_tdd_frame_index(tdd_frame_index),
    .o_tdd_burst_done(tdd_burst_done)
  );

  // One clk: pulses set before the call are seen by exactly one edge; outputs settle after.
  task automatic adv();
    @(posedge clk);
    #1;
    tdd_sync_soft = 1'b0;
    tdd_stop      = 1'b0;
    #1;
  endtask

  task automatic rearm();
    tdd_enable = 1'b0;
    adv();
    tdd_enable = 1'b1;
    adv();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    adv();
    adv();
    n_checks++;
    if ({tdd_cstate, tdd_counter, tdd_frame_index, tdd_tick, tdd_endof_frame, tdd_burst_done}
        !== 69'd0) begin
      n_fail++;
      $display("FAIL reset outputs: got st=%0d cnt=%0d idx=%0d tick=%0b eof=%0b bd=%0b, want all 0",
               tdd_cstate, tdd_counter, tdd_frame_index, tdd_tick, tdd_endof_frame,
               tdd_burst_done);
    end
    rst = 1'b0;
    adv();
    n_checks++;
    if (tdd_cstate !== 2'd1) begin
      n_fail++;
      $display("FAIL reset_to_armed: got st=%0d want 1", tdd_cstate);
    end
    adv();
    n_checks++;
    if ({tdd_cstate, tdd_counter, tdd_tick} !== {2'd1, 32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL armed_hold: got st=%0d cnt=%0d tick=%0b want st=1 cnt=0 tick=0",
               tdd_cstate, tdd_counter, tdd_tick);
    end
  endtask

  // prescale 0, delay 3, length 5, burst 2
  task automatic test_burst();
    int e_st [14]  = '{2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 1};
    int e_cnt [14] = '{0, 1, 2, 0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
    int e_idx [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0};
    logic [68:0] got, want;
    tdd_prescale = 8'd0; tdd_startup_delay = 32'd3; tdd_frame_length = 32'd5;
    tdd_burst_count = 32'd2;
    tdd_sync_soft = 1'b1;
    adv();
    for (int c = 0; c < 14; c++) begin
      got  = {tdd_cstate, tdd_counter, tdd_frame_index, tdd_tick, tdd_endof_frame,
              tdd_burst_done};
      want = {2'(e_st[c]), 32'(e_cnt[c]), 32'(e_idx[c]), c < 13, c == 7 || c == 12, c == 12};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL burst c%0d: got %h want %h (st,cnt,idx,tick,eof,bd)", c, got, want);
      end
      adv();
    end
  endtask

  // prescale 2, delay 0, length 4, burst 1
  task automatic test_prescale();
    logic [68:0] got, want;
    tdd_prescale = 8'd2; tdd_startup_delay = 32'd0; tdd_frame_length = 32'd4;
    tdd_burst_count = 32'd1;
    tdd_sync_soft = 1'b1;
    adv();
    for (int c = 0; c < 13; c++) begin
      got  = {tdd_cstate, tdd_counter, tdd_frame_index, tdd_tick, tdd_endof_frame,
              tdd_burst_done};
      want = {(c < 12) ? 2'd3 : 2'd1, (c < 12) ? 32'(c / 3) : 32'd0, 32'd0,
              (c < 12) && (c % 3 == 2), c == 11, c == 11};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL prescale c%0d: got %h want %h (st,cnt,idx,tick,eof,bd)", c, got, want);
      end
      adv();
    end
  endtask

  // infinite burst, length 2, ext sync held high 10 clk with sync_rst armed
  task automatic test_ext_sync();
    logic [68:0] got, want;
    tdd_prescale = 8'd0; tdd_startup_delay = 32'd0; tdd_frame_length = 32'd2;
    tdd_burst_count = 32'd0; tdd_sync_ext_en = 1'b1; tdd_sync_rst = 1'b1;
    tdd_sync_ext = 1'b1;
    adv();
    for (int c = 0; c < 12; c++) begin
      got  = {tdd_cstate, tdd_counter, tdd_frame_index, tdd_tick, tdd_endof_frame,
              tdd_burst_done};
      want = {2'd3, 32'(c % 2), 32'(c / 2), 1'b1, c % 2 == 1, 1'b0};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL ext_sync c%0d: got %h want %h (st,cnt,idx,tick,eof,bd)", c, got, want);
      end
      if (c == 9) tdd_sync_ext = 1'b0;
      adv();
    end
    tdd_sync_ext_en = 1'b0;
    tdd_sync_rst    = 1'b0;
    rearm();
  endtask

  // infinite burst, length 3, stop during frame 2; then stop during WAITING
  task automatic test_stop();
    logic [68:0] got, want;
    tdd_prescale = 8'd0; tdd_startup_delay = 32'd0; tdd_frame_length = 32'd3;
    tdd_burst_count = 32'd0;
    tdd_sync_soft = 1'b1;
    adv();
    for (int c = 0; c < 11; c++) begin
      got  = {tdd_cstate, tdd_counter, tdd_frame_index, tdd_tick, tdd_endof_frame,
              tdd_burst_done};
      if (c <= 8) want = {2'd3, 32'(c % 3), 32'(c / 3), 1'b1, c % 3 == 2, 1'b0};
      else        want = {2'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL stop_run c%0d: got %h want %h (st,cnt,idx,tick,eof,bd)", c, got, want);
      end
      if (c == 7) tdd_stop = 1'b1;
      adv();
    end
    tdd_startup_delay = 32'd4;
    tdd_sync_soft = 1'b1;
    adv();
    adv();
    n_checks++;
    if ({tdd_cstate, tdd_counter} !== {2'd2, 32'd1}) begin
      n_fail++;
      $display("FAIL stop_wait_pre: got st=%0d cnt=%0d want st=2 cnt=1", tdd_cstate, tdd_counter);
    end
    tdd_stop = 1'b1;
    adv();
    n_checks++;
    if ({tdd_cstate, tdd_counter, tdd_tick} !== {2'd1, 32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL stop_wait: got st=%0d cnt=%0d tick=%0b want st=1 cnt=0 tick=0",
               tdd_cstate, tdd_counter, tdd_tick);
    end
    tdd_stop = 1'b1;
    adv();
    tdd_sync_soft = 1'b1;
    adv();
    n_checks++;
    if ({tdd_cstate, tdd_counter} !== {2'd2, 32'd0}) begin
      n_fail++;
      $display("FAIL stop_armed_ignored: got st=%0d cnt=%0d want st=2 cnt=0",
               tdd_cstate, tdd_counter);
    end
    rearm();
  endtask

  // internal generator period 20, delay 2, length 8, infinite; with and without sync_rst
  task automatic test_int_sync();
    logic [68:0] got, want;
    int r;
    for (int pass = 0; pass < 2; pass++) begin
      tdd_prescale = 8'd0; tdd_startup_delay = 32'd2; tdd_frame_length = 32'd8;
      tdd_burst_count = 32'd0; tdd_sync_period = 32'd20; tdd_sync_int_en = 1'b1;
      tdd_sync_rst = (pass == 0);
      tdd_enable = 1'b0;
      adv();
      tdd_enable = 1'b1;
      for (int i = 0; i < 19; i++) adv();
      n_checks++;
      if (tdd_cstate !== 2'd1) begin
        n_fail++;
        $display("FAIL int_sync_armed p%0d: got st=%0d want 1", pass, tdd_cstate);
      end
      adv();
      for (int s = 0; s < 45; s++) begin
        r = (pass == 0) ? s % 20 : s;
        got  = {tdd_cstate, tdd_counter, tdd_frame_index, tdd_tick, tdd_endof_frame,
                tdd_burst_done};
        want = {(r < 2) ? 2'd2 : 2'd3, (r < 2) ? 32'(r) : 32'((r - 2) % 8),
                (r < 2) ? 32'd0 : 32'((r - 2) / 8), 1'b1, (r >= 2) && ((r - 2) % 8 == 7),
                1'b0};
        n_checks++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL int_sync p%0d s%0d: got %h want %h (st,cnt,idx,tick,eof,bd)",
                   pass, s, got, want);
        end
        adv();
      end
    end
    tdd_sync_int_en = 1'b0;
    tdd_sync_rst    = 1'b0;
    tdd_sync_period = 32'd0;
    rearm();
  endtask

  // reset and enable drop mid-RUNNING, then zero frame length
  task automatic test_abort_and_zero_len();
    logic [68:0] got, want;
    tdd_prescale = 8'd0; tdd_startup_delay = 32'd0; tdd_frame_length = 32'd5;
    tdd_burst_count = 32'd0;
    tdd_sync_soft = 1'b1;
    for (int i = 0; i < 7; i++) adv();
    rst = 1'b1;
    adv();
    n_checks++;
    if ({tdd_cstate, tdd_counter, tdd_frame_index, tdd_tick, tdd_endof_frame, tdd_burst_done}
        !== 69'd0) begin
      n_fail++;
      $display("FAIL rst_mid_run: got st=%0d cnt=%0d idx=%0d tick=%0b eof=%0b bd=%0b, want all 0",
               tdd_cstate, tdd_counter, tdd_frame_index, tdd_tick, tdd_endof_frame,
               tdd_burst_done);
    end
    rst = 1'b0;
    adv();
    tdd_sync_soft = 1'b1;
    for (int i = 0; i < 7; i++) adv();
    n_checks++;
    if ({tdd_cstate, tdd_frame_index} !== {2'd3, 32'd1}) begin
      n_fail++;
      $display("FAIL pre_disable: got st=%0d idx=%0d want st=3 idx=1", tdd_cstate,
               tdd_frame_index);
    end
    tdd_enable = 1'b0;
    adv();
    n_checks++;
    if ({tdd_cstate, tdd_counter, tdd_frame_index, tdd_tick, tdd_endof_frame, tdd_burst_done}
        !== 69'd0) begin
      n_fail++;
      $display("FAIL disable_mid_run: got st=%0d cnt=%0d idx=%0d tick=%0b eof=%0b bd=%0b, want all 0",
               tdd_cstate, tdd_counter, tdd_frame_index, tdd_tick, tdd_endof_frame,
               tdd_burst_done);
    end
    tdd_enable = 1'b1;
    adv();
    tdd_frame_length = 32'd0;
    tdd_sync_soft = 1'b1;
    adv();
    for (int c = 0; c < 6; c++) begin
      got  = {tdd_cstate, tdd_counter, tdd_frame_index, tdd_tick, tdd_endof_frame,
              tdd_burst_done};
      want = {2'd3, 32'd0, 32'(c), 1'b1, 1'b1, 1'b0};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL zero_len c%0d: got %h want %h (st,cnt,idx,tick,eof,bd)", c, got, want);
      end
      adv();
    end
    rearm();
    tdd_burst_count = 32'd2;
    tdd_sync_soft = 1'b1;
    adv();
    for (int c = 0; c < 3; c++) begin
      got  = {tdd_cstate, tdd_counter, tdd_frame_index, tdd_tick, tdd_endof_frame,
              tdd_burst_done};
      if (c < 2) want = {2'd3, 32'd0, 32'(c), 1'b1, 1'b1, c == 1};
      else       want = {2'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL zero_len_burst c%0d: got %h want %h (st,cnt,idx,tick,eof,bd)",
                 c, got, want);
      end
      adv();
    end
  endtask

  initial begin
    rst = 1'b1; tdd_enable = 1'b1; tdd_sync_ext = 1'b0; tdd_sync_ext_en = 1'b0;
    tdd_sync_int_en = 1'b0; tdd_sync_soft = 1'b0; tdd_sync_rst = 1'b0; tdd_stop = 1'b0;
    tdd_prescale = 8'd0; tdd_burst_count = 32'd0; tdd_startup_delay = 32'd0;
    tdd_frame_length = 32'd1; tdd_sync_period = 32'd0;
    test_reset();
    test_burst();
    test_prescale();
    test_ext_sync();
    test_stop();
    test_int_sync();
    test_abort_and_zero_len();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_tdd_ng_seq_counter.md
Name: axi_tdd_ng_seq_counter

Overview:
Parametrised next-generation TDD frame counter for the axi_tdd_ng core. It generates the frame timebase (startup delay, frame counter, burst of N frames) that the channel comparators consume. New relative to the current counter: clock prescaler, internal periodic sync generator, edge-detected external sync, infinite-burst mode, graceful stop at end of frame, frame index output and burst-done status.

Parameters:
REGISTER_WIDTH, 32, width of delay, frame length, sync period and the tdd_counter output
BURST_COUNT_WIDTH, 32, width of burst count and frame index
PRESCALER_WIDTH, 8, width of the tick prescaler register

Ports:
clk  in  1  core clock; the only clock
rst  in  1  synchronous reset, active-high
tdd_enable  in  1  level; low forces IDLE and clears all counters
tdd_sync_ext  in  1  external sync, level; rising edge used
tdd_sync_ext_en  in  1  enables external sync source
tdd_sync_int_en  in  1  enables internal periodic sync generator
tdd_sync_soft  in  1  one-cycle software sync pulse
tdd_sync_rst  in  1  sync during WAITING/RUNNING restarts the sequence
tdd_stop  in  1  one-cycle request: finish current frame, return to ARMED
tdd_prescale  in  PRESCALER_WIDTH  tick every tdd_prescale+1 clk
tdd_burst_count  in  BURST_COUNT_WIDTH  frames per burst; 0 = infinite
tdd_startup_delay  in  REGISTER_WIDTH  ticks from sync to first frame
tdd_frame_length  in  REGISTER_WIDTH  ticks per frame; 0 treated as 1
tdd_sync_period  in  REGISTER_WIDTH  internal sync period in clk; 0 = no pulses
tdd_counter  out  REGISTER_WIDTH  tick count within delay/frame
tdd_cstate  out  2  IDLE=0, ARMED=1, WAITING=2, RUNNING=3
tdd_tick  out  1  prescaler tick, qualified by WAITING/RUNNING
tdd_endof_frame  out  1  one-clk pulse on terminal tick of each frame
tdd_frame_index  out  BURST_COUNT_WIDTH  frame number within burst, 0-based
tdd_burst_done  out  1  one-clk pulse when a finite burst completes

Behaviour:
- rst or tdd_enable=0: next clk all state cleared; all outputs 0, tdd_cstate=IDLE; sync generator, edge detector, stop latch cleared.
- Prescaler: counts clk only in WAITING/RUNNING, else held at 0; tick when prescaler==tdd_prescale, then wraps to 0. prescale=0 -> tick every clk.
- sync_event (combinational) = (ext_en & rising edge of tdd_sync_ext, 1-clk registered history) | (int_en & generator pulse) | tdd_sync_soft. Generator: free-runs while tdd_enable, pulse when count==period-1, then wraps.
- IDLE -> ARMED one clk after tdd_enable=1.
- ARMED: on sync_event -> WAITING if startup_delay!=0, else RUNNING directly; counter, prescaler, frame_index = 0.
- WAITING: counter +1 per tick; on tick with counter==delay-1 -> RUNNING, counter 0.
- RUNNING: counter +1 per tick; terminal tick = tick with counter==max(frame_length,1)-1. At terminal tick: tdd_endof_frame=1 (registered output, coincides with the clk where counter shows the terminal value), counter -> 0.
  - If stop latched: -> ARMED, frame_index 0; no burst_done.
  - Else if burst_count!=0 and frame_index==burst_count-1: -> ARMED, tdd_burst_done pulse same clk as endof_frame, frame_index 0.
  - Else frame_index +1 (wraps at 2^BURST_COUNT_WIDTH in infinite mode).
- tdd_stop: latched in WAITING/RUNNING; in WAITING -> ARMED immediately; cleared on state leaving RUNNING/WAITING. Ignored in IDLE/ARMED.
- Resync: sync_event with tdd_sync_rst=1 in WAITING/RUNNING restarts as if from ARMED (delay reapplied), frame_index 0; takes priority over terminal tick in the same clk. With tdd_sync_rst=0 sync is ignored outside ARMED.
- Registers (delay, length, count) sampled live; changing them mid-frame is allowed, compares use current values; counter past a shrunk length wraps at REGISTER_WIDTH (software responsibility).
- Priority per clk: rst > !tdd_enable > resync > stop > terminal tick > count.

Test Plan:
- prescale=0, delay=3, length=5, burst=2, soft sync -> WAITING 3 clk, RUNNING 10 clk, endof_frame at clk 7 and 12 after sync, burst_done with second, back to ARMED.
- prescale=2, delay=0, length=4, burst=1 -> direct to RUNNING, tick every 3 clk, endof_frame after 12 clk, counter holds value between ticks.
- burst=0, length=2, ext sync edge held high 10 clk -> single start only, frame_index 0,1,2,...; never burst_done.
- Infinite burst, tdd_stop mid-frame 2 -> frame 2 completes with endof_frame, state ARMED, no burst_done; stop in WAITING -> ARMED next clk.
- int_en, period=20, sync_rst=1, delay=2, length=8, burst=0 -> restart every 20 clk, counter and frame_index zeroed; sync_rst=0 -> only first pulse acts.
- rst or tdd_enable drop mid-RUNNING -> next clk IDLE, all outputs 0; frame_length=0 -> endof_frame every tick.
